// File: rtl/ffo_normalize_pipe.sv
// Two-stage leading/trailing-one finder and normaliser with valid/ready flow control.
// S1 registers per-nibble summaries; S2 picks the winning nibble, builds the index and shifts.
module ffo_normalize_pipe #(
    parameter  int WIDTH = 24,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_lsb_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_found,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_shift,
    output logic [WIDTH-1:0] out_norm
);
    localparam int NIB = (WIDTH + 3) / 4;
    localparam int PW  = NIB * 4;

    // Handshake: a stage advances when it is empty or its successor advances.
    // Inputs transfer on in_valid & in_ready; results leave on out_valid & out_ready.
    logic s1_adv, s2_adv;

    logic                     s1_valid_q;
    logic [WIDTH-1:0]         s1_word_q;
    logic                     s1_lsb_q;
    logic [NIB-1:0]           s1_any_q, s1_any_d;
    logic [NIB-1:0][1:0]      s1_sub_q, s1_sub_d;

    logic                     s2_valid_q;
    logic                     s2_found_q, s2_found_d;
    logic [IDX_W-1:0]         s2_index_q, s2_index_d;
    logic [IDX_W-1:0]         s2_shift_q, s2_shift_d;
    logic [WIDTH-1:0]         s2_norm_q, s2_norm_d;

    logic [PW-1:0]            padded;
    logic [3:0]               nib;
    int                       win_idx;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // Sub-index inside each nibble already reflects the search direction of its word.
    always_comb begin
        padded   = PW'(in_word);
        nib      = '0;
        s1_any_d = '0;
        s1_sub_d = '0;
        for (int n = 0; n < NIB; n++) begin
            nib         = padded[4*n +: 4];
            s1_any_d[n] = |nib;
            if (in_lsb_mode) begin
                s1_sub_d[n] = nib[0] ? 2'd0 : nib[1] ? 2'd1 : nib[2] ? 2'd2 : 2'd3;
            end else begin
                s1_sub_d[n] = nib[3] ? 2'd3 : nib[2] ? 2'd2 : nib[1] ? 2'd1 : 2'd0;
            end
        end
    end

    // MSB mode lets later (higher) nibbles overwrite; LSB mode keeps the first hit.
    always_comb begin
        s2_found_d = 1'b0;
        win_idx    = 0;
        s2_index_d = '0;
        s2_shift_d = '0;
        s2_norm_d  = '0;
        for (int n = 0; n < NIB; n++) begin
            if (s1_any_q[n] && (!s1_lsb_q || !s2_found_d)) begin
                s2_found_d = 1'b1;
                win_idx    = n * 4 + int'(s1_sub_q[n]);
            end
        end
        if (s2_found_d) begin
            s2_index_d = IDX_W'(win_idx);
            if (s1_lsb_q) begin
                s2_shift_d = s2_index_d;
                s2_norm_d  = s1_word_q >> s2_shift_d;
            end else begin
                s2_shift_d = IDX_W'(WIDTH - 1) - s2_index_d;
                s2_norm_d  = s1_word_q << s2_shift_d;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '0;
            s1_lsb_q   <= 1'b0;
            s1_any_q   <= '0;
            s1_sub_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_word_q <= in_word;
                s1_lsb_q  <= in_lsb_mode;
                s1_any_q  <= s1_any_d;
                s1_sub_q  <= s1_sub_d;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_found_q <= 1'b0;
            s2_index_q <= '0;
            s2_shift_q <= '0;
            s2_norm_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_found_q <= s2_found_d;
                s2_index_q <= s2_index_d;
                s2_shift_q <= s2_shift_d;
                s2_norm_q  <= s2_norm_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_found = s2_found_q;
    assign out_index = s2_index_q;
    assign out_shift = s2_shift_q;
    assign out_norm  = s2_norm_q;

endmodule
